// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus arbiter.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RESP  = 2'd2,
        GUARD = 2'd3
    } arb_state_t;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int XFER_BITS      = ADDR_WIDTH_DEF + DATA_WIDTH_DEF;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

endpackage

// File: rtl/serial_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_MASTERS. Produces a one-hot grant and its index.
module rr_picker
    import serial_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [PTR_W-1:0]       winner
);

    logic found;

    // Scan from ptr upward first, then wrap around to the low indices.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                winner = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                winner = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one bit-serial bus between NUM_MASTERS masters.
// Optional build macro ARB_TIMEOUT_EN adds a read-response timeout that
// pulses timeout_err and releases the bus after TIMEOUT_CYCLES RESP cycles.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_valid,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_wr_bus,
    input  logic [NUM_MASTERS-1:0] m_ready,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [NUM_MASTERS-1:0] m_sready,
    output logic [NUM_MASTERS-1:0] m_svalid,
    output logic                   bus_valid,
    output logic                   bus_mode,
    output logic                   bus_wr,
    output logic                   bus_mready,
    input  logic                   s_ready,
    input  logic                   s_valid,
    output logic                   timeout_err
);

    localparam int NBITS = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam int PTR_W = $clog2(NUM_MASTERS);

    arb_state_t             state, state_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   mode_q;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [PTR_W-1:0]       pick_idx;
    logic                   active, sel_valid, accept, last_bit, handshake, expired;

    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req    (m_valid),
        .ptr    (ptr_q),
        .gnt    (pick_gnt),
        .winner (pick_idx)
    );

    // The bus carries the granted master only while a transfer or response is live.
    assign active     = (state == XFER) || (state == RESP);
    assign sel_valid  = |(m_valid & grant_q);
    assign bus_valid  = active & sel_valid;
    assign bus_mode   = active & |(m_mode & grant_q);
    assign bus_wr     = active & |(m_wr_bus & grant_q);
    assign bus_mready = active & |(m_ready & grant_q);
    assign m_sready   = (active && s_ready) ? grant_q : '0;
    assign m_svalid   = (active && s_valid) ? grant_q : '0;
    assign m_grant    = grant_q;

    assign accept    = (state == XFER) && bus_valid && s_ready;
    assign last_bit  = accept && (cnt_q == CNT_W'(NBITS - 1));
    assign handshake = (state == RESP) && s_valid && bus_mready;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign expired     = (state == RESP) && !handshake && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    // RESP dwell counter restarts on every entry; error is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= expired;
            tmo_q <= (state == RESP) ? tmo_q + 1'b1 : '0;
        end
    end
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register; reset aborts any transfer with no guard cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic: grant, shift bits, optional read response, one guard cycle.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|m_valid) state_d = XFER;
            XFER:    if (!sel_valid)    state_d = GUARD;
                     else if (last_bit) state_d = (mode_q == MODE_WRITE) ? GUARD : RESP;
            RESP:    if (handshake || expired) state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, round-robin pointer, latched mode and bit counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_READ;
        end else begin
            case (state)
                IDLE: if (|m_valid) begin
                    grant_q <= pick_gnt;
                    mode_q  <= |(m_mode & pick_gnt);
                    ptr_q   <= (pick_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_q   <= '0;
                end
                XFER:    if (accept) cnt_q <= cnt_q + 1'b1;
                GUARD:   grant_q <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares one bit-serial system bus (address-then-data, mode-select, valid/ready handshakes) between NUM_MASTERS masters and one slave port.
- Grants round-robin and muxes the granted master's signals onto the bus.
- Tracks each transaction to completion: all bits shifted for writes; read-response handshake for reads.
- Releases the bus with one guard cycle so the slave returns to IDLE before the next grant.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (>=2).
- ADDR_WIDTH, 16, serial address bits per transaction.
- DATA_WIDTH, 8, serial data bits per transaction.
- TIMEOUT_CYCLES, 64, read-response timeout (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; synchronous, active-low.
- m_valid  input  NUM_MASTERS  per-master valid; doubles as bus request.
- m_mode  input  NUM_MASTERS  per-master mode: 1 = write, 0 = read.
- m_wr_bus  input  NUM_MASTERS  per-master serial write bit.
- m_ready  input  NUM_MASTERS  per-master ready for read response.
- m_grant  output  NUM_MASTERS  one-hot grant.
- m_sready  output  NUM_MASTERS  s_ready routed to the granted master only.
- m_svalid  output  NUM_MASTERS  s_valid routed to the granted master only.
- bus_valid  output  1  master_valid to the slave.
- bus_mode  output  1  mode to the slave.
- bus_wr  output  1  wr_bus to the slave.
- bus_mready  output  1  master_ready to the slave.
- s_ready  input  1  slave_ready from the slave.
- s_valid  input  1  slave_valid from the slave.
- timeout_err  output  1  one-cycle pulse on read timeout (only with ARB_TIMEOUT_EN; otherwise tied 0).

Behaviour:
- Reset: state IDLE; m_grant = 0; rr pointer = 0; bit counter = 0.
  - All bus_* outputs, m_sready, m_svalid and timeout_err = 0.
  - Reset mid-transaction aborts immediately with no guard cycle.
- Datapath mux:
  - bus_* = granted master's signals while state is XFER or RESP; otherwise 0.
  - m_sready/m_svalid are nonzero only in the granted bit.
- States: IDLE, XFER, RESP, GUARD.
- IDLE:
  - If any m_valid is set, pick the first set bit at or after the pointer, wrapping modulo NUM_MASTERS.
  - Register one-hot m_grant, latch the granted master's mode into mode_q, set the pointer to (winner+1) mod NUM_MASTERS, clear the counter, go to XFER.
  - Latency: m_valid high at edge t gives m_grant and bus_valid visible after edge t; the grant is held through GUARD.
- XFER:
  - Counter increments on each cycle with bus_valid && s_ready.
  - Counter width is $clog2(ADDR_WIDTH+DATA_WIDTH+1).
  - If the granted m_valid is low while count < ADDR_WIDTH+DATA_WIDTH, abort to GUARD.
  - When count reaches ADDR_WIDTH+DATA_WIDTH: if mode_q = 1 go to GUARD, else go to RESP.
- RESP:
  - Wait for s_valid && bus_mready; on that handshake go to GUARD.
  - m_valid is ignored in RESP.
- GUARD:
  - Exactly one cycle with bus_valid = 0; m_grant is cleared at exit; go to IDLE.
  - A new grant therefore arrives no earlier than the cycle after GUARD.
- Fairness: a master requesting continuously is served at most once per NUM_MASTERS grants while others request.
- Request changes: m_valid changes of non-granted masters during a transaction have no effect.
- mode_q: a mid-transaction change of the granted m_mode is not used for completion tracking; bus_mode still follows the live input.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - RESP counts cycles from entry.
  - After TIMEOUT_CYCLES cycles without a handshake: pulse timeout_err for one cycle and go to GUARD.
  - A handshake in the same cycle as expiry counts as success, with no error pulse.
- Undefined: no timeout counter; RESP waits indefinitely; timeout_err tied 0.

Decomposition:
- Package serial_bus_pkg:
  - arb_state_t enum {IDLE, XFER, RESP, GUARD}.
  - localparam XFER_BITS = ADDR_WIDTH+DATA_WIDTH defaults.
  - MODE_WRITE = 1, MODE_READ = 0.
- Sub-module rr_picker:
  - Combinational; inputs req[NUM_MASTERS] and ptr.
  - Outputs one-hot gnt and winner index.
  - Instantiated once in IDLE grant logic.

Test Plan:
- Single write: m_valid = 4'b0010, mode 1, 24 bits, s_ready held 1.
  - m_grant = 4'b0010 after one edge; GUARD after the 24th accepted bit.
  - m_grant = 0 two cycles later; the slave RAM holds the data.
- Read: master 0, mode 0, slave returns s_valid, m_ready = 1.
  - RESP entered after 24 bits; m_svalid[0] = 1, other bits 0; GUARD then IDLE.
- Round-robin: all four m_valid held high across transactions.
  - Grant order 0, 1, 2, 3, 0.
  - Exactly one GUARD cycle with bus_valid = 0 between grants.
- Abort: master 2 drops m_valid after 5 address bits.
  - GUARD next cycle; pointer = 3.
  - A pending master 3 is granted after GUARD.
- Reset mid-XFER: rstn low for one cycle at bit 10.
  - All outputs 0 after the edge; pointer = 0; next request is granted normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, read with s_valid never high.
  - timeout_err pulses 8 cycles after RESP entry; then GUARD and IDLE.
